dmem_responder: RTL and testbench

- Data-memory responder serving the pipeline's memory stage: accepts load/store requests (address = ALU result, store data = forwarded rs2) and returns load data after a configurable number of wait states.
- Drives a stall request back to the hazard logic while an access is outstanding.
- Holds a word-organised RAM with byte/halfword/word access, sign/zero extension, and misalignment and out-of-range error detection.

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: serialised load/store access
// with programmable wait states, pipeline stall request, byte/half/word lanes
// with sign/zero extension, and misalignment / out-of-range rejection.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

   state_t            state;
   state_t            nextState;
   logic [3:0]        waitCnt;
   logic              capWe;
   logic              capUnsigned;
   logic [1:0]        capSize;
   logic [31:0]       capAddr;
   logic [31:0]       capWdata;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       reqOffset;
   logic              reqBad;
   logic              doAccess;
   logic [IDX_W-1:0]  wordIdx;
   logic [31:0]       rdWord;
   logic [7:0]        byteLane;
   logic [15:0]       halfLane;
   logic [31:0]       loadVal;
   logic [31:0]       wrData;
   logic [3:0]        byteEn;

   // Validate the live request: illegal size, misalignment, or outside the RAM window
   always_comb begin
      reqOffset = req_addr - BASE_ADDR;
      case (req_size)
         2'b01:   reqBad = req_addr[0];
         2'b10:   reqBad = (req_addr[1:0] != 2'b00);
         2'b11:   reqBad = 1'b1;
         default: reqBad = 1'b0;
      endcase
      if ({1'b0, reqOffset} >= SPAN_BYTES) reqBad = 1'b1;
   end

   // Read the captured word, select the addressed lane and extend it
   always_comb begin
      wordIdx = IDX_W'((capAddr - BASE_ADDR) >> 2);
      rdWord  = mem[wordIdx];
      case (capAddr[1:0])
         2'b00:   byteLane = rdWord[7:0];
         2'b01:   byteLane = rdWord[15:8];
         2'b10:   byteLane = rdWord[23:16];
         default: byteLane = rdWord[31:24];
      endcase
      halfLane = capAddr[1] ? rdWord[31:16] : rdWord[15:0];
      case (capSize)
         2'b00:   loadVal = {{24{~capUnsigned & byteLane[7]}}, byteLane};
         2'b01:   loadVal = {{16{~capUnsigned & halfLane[15]}}, halfLane};
         default: loadVal = rdWord;
      endcase
   end

   // Byte enables and lane-replicated store data for the captured store
   always_comb begin
      case (capSize)
         2'b00: begin
            byteEn = 4'b0001 << capAddr[1:0];
            wrData = {4{capWdata[7:0]}};
         end
         2'b01: begin
            byteEn = capAddr[1] ? 4'b1100 : 4'b0011;
            wrData = {2{capWdata[15:0]}};
         end
         default: begin
            byteEn = '1;
            wrData = capWdata;
         end
      endcase
   end

   assign doAccess = (state == BUSY) && (waitCnt == 4'd0);

   // RAM write on the last wait-state edge; reset forces IDLE so an aborted store never lands
   always_ff @(posedge clk) begin
      if (doAccess && capWe) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

   // State register, wait counter and request capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         waitCnt     <= '0;
         capWe       <= 1'b0;
         capUnsigned <= 1'b0;
         capSize     <= '0;
         capAddr     <= '0;
         capWdata    <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  capWe       <= req_we;
                  capUnsigned <= req_unsigned;
                  capSize     <= req_size;
                  capAddr     <= req_addr;
                  capWdata    <= req_wdata;
                  waitCnt     <= 4'(LATENCY - 1);
               end
            end
            BUSY: begin
               if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Load result register: cleared on a rejected request, held across stores
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (state == IDLE && req_valid && reqBad) begin
         rdata <= '0;
      end else if (doAccess && !capWe) begin
         rdata <= loadVal;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      nextState  = state;
      stall      = 1'b0;
      resp_valid = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            stall = req_valid;
            if (req_valid) nextState = reqBad ? ERR : BUSY;
         end
         BUSY: begin
            stall = 1'b1;
            if (waitCnt == 4'd0) nextState = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            nextState  = IDLE;
         end
         ERR: begin
            err       = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level memory model with
// per-cycle expected stall/resp_valid/err/rdata, directed cases and random traffic.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelMem [DEPTH];
   logic [31:0] lastRdata;

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY(LAT),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .stall(stall),
      .resp_valid(resp_valid),
      .rdata(rdata),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h want=%08h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic expectOut(input string tag, input logic eStall, input logic eResp,
                            input logic eErr, input logic [31:0] eRdata);
      chk({tag, ".stall"}, 32'(stall), 32'(eStall));
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(eResp));
      chk({tag, ".err"}, 32'(err), 32'(eErr));
      chk({tag, ".rdata"}, rdata, eRdata);
   endtask

   // Random junk on the request bus while the DUT must ignore it
   task automatic scramble(input logic allowValid);
      req_valid    = allowValid ? 1'($urandom_range(0, 1)) : 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
   endtask

   function automatic logic isBad(input logic [1:0] size, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (size == 2'b11) || (size == 2'b01 && a[0]) ||
             (size == 2'b10 && a[1:0] != 2'b00) || (off >= DEPTH * 4);
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] v;
      int unsigned sh;
      w  = modelMem[(a - BASE) >> 2];
      sh = 8 * int'(a[1:0]);
      if (size == 2'b00) begin
         v = (w >> sh) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> sh) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic modelStore(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int unsigned sh;
      int unsigned idx;
      sh  = 8 * int'(a[1:0]);
      idx = (a - BASE) >> 2;
      if (size == 2'b00)      mask = 32'h0000_00FF << sh;
      else if (size == 2'b01) mask = 32'h0000_FFFF << sh;
      else                    mask = 32'hFFFF_FFFF;
      modelMem[idx] = (modelMem[idx] & ~mask) | ((wd << sh) & mask);
   endtask

   // One complete transaction, checked every cycle; returns rdata seen in DONE/ERR
   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
      logic        bad;
      logic [31:0] expData;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      #1;
      expectOut("req", 1'b1, 1'b0, 1'b0, lastRdata);
      bad = isBad(size, a);
      if (bad) begin
         @(negedge clk);
         scramble(1'b1);
         #1;
         lastRdata = '0;
         expectOut("errcyc", 1'b0, 1'b0, 1'b1, 32'h0);
         got = rdata;
      end else begin
         if (we) begin
            modelStore(size, a, wd);
            expData = lastRdata;
         end else begin
            expData = modelLoad(size, uns, a);
         end
         for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clk);
            scramble(1'b1);
            #1;
            expectOut("busy", 1'b1, 1'b0, 1'b0, lastRdata);
         end
         @(negedge clk);
         scramble(1'b1);
         #1;
         expectOut("done", 1'b0, 1'b1, 1'b0, expData);
         got       = rdata;
         lastRdata = expData;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         scramble(1'b0);
         #1;
         expectOut("idle", 1'b0, 1'b0, 1'b0, lastRdata);
      end
   endtask

   // Word store aborted by reset during the given BUSY cycle (1 = first)
   task automatic resetMidBusy(input logic [31:0] a, input logic [31:0] wd, input int busyCyc);
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = a;
      req_wdata    = wd;
      #1;
      expectOut("rstReq", 1'b1, 1'b0, 1'b0, lastRdata);
      for (int i = 1; i < busyCyc; i++) begin
         @(negedge clk);
         scramble(1'b1);
         #1;
         expectOut("rstBusy", 1'b1, 1'b0, 1'b0, lastRdata);
      end
      @(negedge clk);
      scramble(1'b0);
      reset = 1'b1;
      #1;
      lastRdata = '0;
      expectOut("rstAbort", 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      expectOut("rstHold", 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] prev;
      logic [1:0]  sz;
      logic [31:0] a;
      int unsigned pick;

      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      lastRdata = '0;
      repeat (2) @(negedge clk);
      #1;
      expectOut("reset", 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Give every word a known value
      for (int unsigned w = 0; w < DEPTH; w++) access(1'b1, 2'b10, 1'b0, BASE + 4 * w, $urandom, got);

      // Word store/load
      access(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, got);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, got);
      chk("lit.word", got, 32'hDEAD_BEEF);

      // Byte lanes
      access(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0, prev);
      access(1'b1, 2'b00, 1'b0, BASE + 32'h21, 32'h1234_5680, got);
      access(1'b0, 2'b00, 1'b0, BASE + 32'h21, 32'h0, got);
      chk("lit.byteSigned", got, 32'hFFFF_FF80);
      access(1'b0, 2'b00, 1'b1, BASE + 32'h21, 32'h0, got);
      chk("lit.byteUnsigned", got, 32'h0000_0080);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0, got);
      chk("lit.byteLaneOnly", got, {prev[31:16], 8'h80, prev[7:0]});

      // Halfwords
      access(1'b1, 2'b01, 1'b0, BASE + 32'h32, 32'hABCD_1234, got);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0, got);
      chk("lit.halfUpper", 32'(got[31:16]), 32'h0000_1234);
      access(1'b1, 2'b01, 1'b0, BASE + 32'h32, 32'h0000_8001, got);
      access(1'b0, 2'b01, 1'b0, BASE + 32'h32, 32'h0, got);
      chk("lit.halfSigned", got, 32'hFFFF_8001);

      // Rejected requests, then confirm RAM untouched
      access(1'b0, 2'b10, 1'b0, BASE + 32'h13, 32'h0, got);
      access(1'b0, 2'b01, 1'b0, BASE + 32'h15, 32'h0, got);
      access(1'b0, 2'b11, 1'b0, BASE + 32'h10, 32'h0, got);
      access(1'b0, 2'b10, 1'b0, BASE + DEPTH * 4, 32'h0, got);
      access(1'b1, 2'b11, 1'b0, BASE + 32'h10, 32'h0BAD_F00D, got);
      access(1'b1, 2'b10, 1'b0, BASE + 32'h12, 32'h0BAD_F00D, got);
      access(1'b1, 2'b10, 1'b0, BASE + DEPTH * 4, 32'h0BAD_F00D, got);
      idle(1);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, got);
      chk("lit.afterErr", got, 32'hDEAD_BEEF);

      // Reset aborting a store in its last and first wait cycle
      access(1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'h1357_2468, got);
      resetMidBusy(BASE + 32'h40, 32'hAAAA_5555, 2);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0, got);
      chk("lit.abortLast", got, 32'h1357_2468);
      resetMidBusy(BASE + 32'h40, 32'hAAAA_5555, 1);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0, got);
      chk("lit.abortFirst", got, 32'h1357_2468);

      // Back-to-back loads; junk (incl. req_valid) driven during stall and DONE
      access(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, got);
      access(1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0, got);
      chk("lit.b2b", got, 32'h1357_2468);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         pick = $urandom_range(0, 9);
         sz   = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
         a    = BASE + $urandom_range(0, DEPTH * 4 - 1);
         if ($urandom_range(0, 7) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         if ($urandom_range(0, 11) == 0) a = BASE + DEPTH * 4 + $urandom_range(0, 4096);
         access(1'($urandom), sz, 1'($urandom), a, $urandom, got);
         idle(int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
